btn_debounce_pulse: RTL
=======================

BTN_DEBOUNCE_PULSE -- requirements
Module: btn_debounce_pulse

Interface
REQ-001 Parameter DB_CYCLES, default 4, meaning consecutive stable samples needed to accept a level change; legal range 1..255.
REQ-002 Parameter REPEAT_CYCLES, default 100, meaning auto-repeat period in clk_in cycles; legal range 2..65535; used only when BTN_AUTO_REPEAT_EN is defined.
REQ-003 Port clk_in, input, 1 bit: single clock, the 200 Hz divided clock; all logic on its rising edge.
REQ-004 Port clear, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port inp_0, input, 1 bit: raw asynchronous push-button, "enter 0".
REQ-006 Port inp_1, input, 1 bit: raw asynchronous push-button, "enter 1".
REQ-007 Port clk_pulse, output, 1 bit: one-cycle strobe per accepted press; feeds the FSM clock-enable/pulse input.
REQ-008 Port bit_out, output, 1 bit: value of the accepted press (1 = inp_1, 0 = inp_0); valid whenever clk_pulse is high, held otherwise.
REQ-009 Port conflict, output, 1 bit: one-cycle strobe when a press is rejected by the rules in REQ-016 and REQ-017.
REQ-010 Ports db_0 and db_1, output, 1 bit each: debounced levels of inp_0 and inp_1.

Function
REQ-011 Each input passes through its own 2-flop synchronizer; the second-stage output is the sampled level s_x.
REQ-012 Each input has an 8-bit stability counter: it is cleared in any cycle where s_x equals db_x, and increments where s_x differs from db_x.
REQ-013 db_x toggles on the edge where s_x differs from db_x and the counter equals DB_CYCLES-1; the counter clears on the same edge.
REQ-014 A glitch shorter than DB_CYCLES samples never changes db_x; any single-sample return to the old level restarts the count.
REQ-015 Accept rule: when db_x rises while the other debounced level is 0 and does not rise in the same cycle, clk_pulse is high for exactly the next cycle and bit_out is loaded with x on the same edge.
REQ-016 Simultaneous rule: when db_0 and db_1 rise in the same cycle, no clk_pulse is generated, conflict is high for one cycle, and bit_out is held.
REQ-017 Lockout rule: when db_x rises while the other debounced level is already 1, no clk_pulse is generated, conflict is high for one cycle, and bit_out is held.
REQ-018 Release (falling db_x) never generates clk_pulse or conflict.
REQ-019 Latency: with the input steady from edge 0, db_x changes on edge DB_CYCLES+2 and clk_pulse is high after edge DB_CYCLES+3.
REQ-020 clk_pulse and conflict are registered outputs and are never high in the same cycle.

Reset
REQ-021 While clear is high, all synchronizer flops, counters, db_0, db_1, clk_pulse, bit_out and conflict are 0, independent of clk_in.
REQ-022 Deassertion of clear mid-press treats a held button as a new press: a held button produces a pulse after the normal REQ-019 latency measured from the first edge after release of clear.

Configuration
REQ-023 Macro BTN_AUTO_REPEAT_EN: when defined, a 16-bit repeat counter is compiled in.
REQ-024 With BTN_AUTO_REPEAT_EN defined: while exactly one button's debounced level is 1 and the other is 0, a further clk_pulse with the same bit_out is issued every REPEAT_CYCLES cycles after each pulse for that hold. The counter clears on release or on any conflict, and conflict does not repeat.
REQ-025 Without BTN_AUTO_REPEAT_EN: the repeat counter is absent and one hold yields exactly one clk_pulse.

Verification
REQ-026 Press inp_1 at edge 0 and hold it with DB_CYCLES=4 -> db_1=1 after edge 6, clk_pulse=1 and bit_out=1 for one cycle after edge 7 only.
REQ-027 Toggle inp_0 high for 3 samples, low for 1, then high steadily -> no pulse from the glitch; single pulse with bit_out=0 after edge 7 counted from the final rise.
REQ-028 Raise inp_0 and inp_1 on the same edge -> conflict for one cycle, clk_pulse stays 0, bit_out keeps its prior value.
REQ-029 Hold inp_0, then press inp_1 20 cycles later -> one pulse with bit_out=0, then one conflict cycle, with no second pulse.
REQ-030 Assert clear for 2 cycles while inp_1 is held and db_1=1 -> all outputs 0 immediately; one new pulse 7 edges after clear deasserts.
REQ-031 With BTN_AUTO_REPEAT_EN and REPEAT_CYCLES=10, hold inp_1 for 40 cycles -> first pulse at edge 7, repeats at edges 17, 27 and 37; without the macro -> only the edge-7 pulse.

Source files
------------

// File: rtl/btn_debounce_pulse.sv
// Two-button debouncer producing a one-cycle strobe plus bit value per accepted press.
// Optional auto-repeat while a single button is held: define BTN_AUTO_REPEAT_EN.
module btn_debounce_pulse #(
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_CYCLES = 100
) (
    input  logic clk_in,
    input  logic clear,
    input  logic inp_0,
    input  logic inp_1,
    output logic clk_pulse,
    output logic bit_out,
    output logic conflict,
    output logic db_0,
    output logic db_1
);

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db
        $error("DB_CYCLES out of range 1..255");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_rpt
        $error("REPEAT_CYCLES out of range 2..65535");
    end

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] db_q;
    logic [1:0] db_d;
    logic [1:0] db_prev_q;
    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];
    logic       pulse_q;
    logic       pulse_d;
    logic       bit_q;
    logic       bit_d;
    logic       conflict_q;
    logic       conflict_d;
    logic       accept_0_s;
    logic       accept_1_s;
    logic       rpt_fire_s;

    // Stability counters: a level change is accepted only after DB_CYCLES differing samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = 8'd0;
            db_d[i]  = db_q[i];
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i]  = ~db_q[i];
                    cnt_d[i] = 8'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end else begin
                cnt_d[i] = 8'd0;
            end
        end
    end

    // Press arbitration on registered rising edges of the debounced levels.
    always_comb begin
        logic [1:0] rise_s;
        rise_s     = db_q & ~db_prev_q;
        accept_0_s = rise_s[0] & ~db_q[1] & ~db_prev_q[1];
        accept_1_s = rise_s[1] & ~db_q[0] & ~db_prev_q[0];
        conflict_d = (rise_s[0] & ~accept_0_s) | (rise_s[1] & ~accept_1_s);
        pulse_d    = accept_0_s | accept_1_s | rpt_fire_s;
        if (accept_1_s) begin
            bit_d = 1'b1;
        end else if (accept_0_s) begin
            bit_d = 1'b0;
        end else begin
            bit_d = bit_q;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);

    logic [15:0] rpt_cnt_q;
    logic [15:0] rpt_cnt_d;
    logic        rpt_arm_q;
    logic        rpt_arm_d;

    // Repeat timer is armed by an accepted press and dropped on release or any conflict.
    always_comb begin
        logic hold_s;
        hold_s     = db_q[0] ^ db_q[1];
        rpt_fire_s = rpt_arm_q & hold_s & ~conflict_d & (rpt_cnt_q == RPT_LAST);
        rpt_arm_d  = 1'b0;
        rpt_cnt_d  = 16'd0;
        if (accept_0_s || accept_1_s) begin
            rpt_arm_d = 1'b1;
            rpt_cnt_d = 16'd0;
        end else if (conflict_d || !hold_s || !rpt_arm_q) begin
            rpt_arm_d = 1'b0;
            rpt_cnt_d = 16'd0;
        end else if (rpt_fire_s) begin
            rpt_arm_d = 1'b1;
            rpt_cnt_d = 16'd0;
        end else begin
            rpt_arm_d = 1'b1;
            rpt_cnt_d = rpt_cnt_q + 16'd1;
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk_in or posedge clear) begin
        if (clear) begin
            rpt_cnt_q <= 16'd0;
            rpt_arm_q <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_arm_q <= rpt_arm_d;
        end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

    // Synchronizers, debounce state and registered outputs.
    always_ff @(posedge clk_in or posedge clear) begin
        if (clear) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            db_q       <= 2'b00;
            db_prev_q  <= 2'b00;
            cnt_q[0]   <= 8'd0;
            cnt_q[1]   <= 8'd0;
            pulse_q    <= 1'b0;
            bit_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= {inp_1, inp_0};
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            db_prev_q  <= db_q;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            pulse_q    <= pulse_d;
            bit_q      <= bit_d;
            conflict_q <= conflict_d;
        end
    end

    assign clk_pulse = pulse_q;
    assign bit_out   = bit_q;
    assign conflict  = conflict_q;
    assign db_0      = db_q[0];
    assign db_1      = db_q[1];

endmodule
